// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts the ones in a window of 2**WIDTH
// qualified stream bits and holds the saturated count under valid/ready.
module sc_stream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST_SAMPLE = {WIDTH{1'b1}};

    state_t           state_reg,      state_next;
    logic [WIDTH-1:0] sample_cnt_reg, sample_cnt_next;
    logic [WIDTH:0]   ones_cnt_reg,   ones_cnt_next;
    logic [WIDTH-1:0] result_reg,     result_next;

    logic [WIDTH:0]   ones_sum;
    logic [WIDTH-1:0] result_sat;

    // Running total including the bit presented this cycle.
    assign ones_sum = ones_cnt_reg + {{WIDTH{1'b0}}, in_bit};

    // Only an all-ones window sets the MSB; its low bits are then zero, so
    // OR-ing the MSB into every bit yields 2**WIDTH-1.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sat
            assign result_sat[gi] = ones_sum[gi] | ones_sum[WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            ones_cnt_reg   <= '0;
            result_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            ones_cnt_reg   <= ones_cnt_next;
            result_reg     <= result_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        ones_cnt_next   = ones_cnt_reg;
        result_next     = result_reg;

        if (clear) begin
            state_next      = IDLE;
            sample_cnt_next = '0;
            ones_cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next      = COUNT;
                        sample_cnt_next = '0;
                        ones_cnt_next   = '0;
                    end
                end

                COUNT: begin
                    if (in_valid) begin
                        sample_cnt_next = sample_cnt_reg + 1'b1;
                        ones_cnt_next   = ones_sum;
                        if (sample_cnt_reg == LAST_SAMPLE) begin
                            state_next  = DONE;
                            result_next = result_sat;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            state_next      = COUNT;
                            sample_cnt_next = '0;
                            ones_cnt_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end

                default: begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    ones_cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy      = (state_reg == COUNT);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with WIDTH=4 (16-bit window).
module tb_sc_stream_decoder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    int checks;
    int failures;

    sc_stream_decoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feeds n qualified bits, bits[0] first, one per cycle.
    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            tick();
            if (i == 14) begin
                chk("busy_before_last", {31'd0, busy}, 32'd1);
                chk("no_valid_before_last", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {28'd0, result}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: all-zero window
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        feed(16'h0000, 16);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_busy_fall", {31'd0, busy}, 32'd0);
        chk("t1_result", {28'd0, result}, 32'd0);
        $display("t1 zero window result=%0d", result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_ack_valid", {31'd0, out_valid}, 32'd0);

        // IDLE ignores the stream
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // 3: alternating 1/0, gap every third cycle; 16 qualified bits in 23 cycles
        pulse_start();
        begin
            int q;
            q = 0;
            for (int cyc = 0; cyc < 23; cyc++) begin
                if (cyc % 3 == 2) begin
                    in_valid = 1'b0;
                    in_bit   = 1'b1;
                end else begin
                    in_valid = 1'b1;
                    in_bit   = (q % 2 == 0);
                    q++;
                end
                tick();
                if (cyc == 21)
                    chk("t3_not_early", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_result", {28'd0, result}, 32'd8);
        $display("t3 gapped alternating result=%0d", result);

        // 4: hold in DONE while start and stream toggle
        for (int i = 0; i < 10; i++) begin
            start    = (i % 2 == 0);
            in_valid = 1'b1;
            in_bit   = (i % 2 == 1);
            tick();
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_result", {28'd0, result}, 32'd8);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_keep_result", {28'd0, result}, 32'd8);
        tick();
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        $display("t4 hold/ack result=%0d", result);

        // 2: saturation, and 15 ones + one zero
        pulse_start();
        feed(16'hFFFF, 16);
        chk("t2_sat_result", {28'd0, result}, 32'd15);
        $display("t2 all ones result=%0d", result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        pulse_start();
        feed(16'h7FFF, 16);
        chk("t2_15_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_15_result", {28'd0, result}, 32'd15);
        $display("t2 fifteen ones result=%0d", result);

        // 5: back-to-back restart from DONE
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_valid_low", {31'd0, out_valid}, 32'd0);
        feed(16'hFFFF, 16);
        chk("t5_result", {28'd0, result}, 32'd15);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        feed(16'h0007, 16);
        chk("t5_zeroed_result", {28'd0, result}, 32'd3);
        $display("t5 back-to-back result=%0d", result);

        // clear in DONE keeps result, drops out_valid
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_done_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_done_result", {28'd0, result}, 32'd3);

        // 6: async reset mid-COUNT
        pulse_start();
        feed(16'h007F, 7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_result", {28'd0, result}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        feed(16'h0000, 16);
        chk("t6_new_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_new_result", {28'd0, result}, 32'd0);
        $display("t6 after reset result=%0d", result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // clear mid-COUNT: back to IDLE, later stream never completes
        pulse_start();
        feed(16'h001F, 5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cnt_busy", {31'd0, busy}, 32'd0);
        chk("clr_cnt_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        chk("clr_no_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_result", {28'd0, result}, 32'd0);
        $display("t6 clear mid-count valid=%0d", out_valid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
